systolic_seq_ctrl: RTL and testbench

//  Sequencer for the NxN output-stationary systolic array of PE cells.
//  - Holds one NxN A operand matrix and one NxN B operand matrix in local register buffers.
//  - On start, clears the PE accumulators, then streams skewed A rows into the west edge
//    and skewed B columns into the north edge.
//  - Signals done once the last product has been accumulated in PE(N-1,N-1).
//  - Sits between the host/load logic and the array; drives the array's en, rst, A and B inputs.

---
 rtl/systolic_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq_ctrl
// Brief    : Operand buffers and skewed edge feeder for an NxN systolic array.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       ld_en,
    input  logic                       ld_sel,
    input  logic [2*$clog2(N)-1:0]     ld_addr,
    input  logic [DW-1:0]              ld_data,
    output logic                       arr_en,
    output logic                       arr_rst,
    output logic [N*DW-1:0]            a_west,
    output logic [N*DW-1:0]            b_north,
    output logic                       busy,
    output logic                       done
);

    localparam int c_IW   = $clog2(N);
    localparam int c_LAST = 3*N - 3;
    localparam int c_SW   = (c_LAST > 0) ? $clog2(c_LAST + 1) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CLEAR = 2'd1;
    localparam logic [1:0] c_FEED  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [c_SW-1:0] r_step;
    logic            r_arr_en;
    logic            r_arr_rst;
    logic            r_busy;
    logic            r_done;

    logic [DW-1:0]   r_a [N][N];
    logic [DW-1:0]   r_b [N][N];

    logic [c_IW-1:0] w_row;
    logic [c_IW-1:0] w_col;
    logic            w_ld_ok;
    logic [N*DW-1:0] w_a_west;
    logic [N*DW-1:0] w_b_north;

    assign w_row   = ld_addr[2*c_IW-1 -: c_IW];
    assign w_col   = ld_addr[c_IW-1:0];
    // Buffers stay frozen while the array is consuming them.
    assign w_ld_ok = ld_en && ((r_state == c_IDLE) || (r_state == c_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    r_a[i][k] <= '0;
                    r_b[i][k] <= '0;
                end
            end
        end else if (w_ld_ok) begin
            if (ld_sel) r_b[w_row][w_col] <= ld_data;
            else        r_a[w_row][w_col] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_step    <= '0;
            r_arr_en  <= 1'b0;
            r_arr_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state   <= c_CLEAR;
                        r_arr_rst <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                c_CLEAR: begin
                    r_state   <= c_FEED;
                    r_step    <= '0;
                    r_arr_rst <= 1'b0;
                    r_arr_en  <= 1'b1;
                end
                c_FEED: begin
                    if (r_step == c_SW'(c_LAST)) begin
                        r_state  <= c_DONE;
                        r_step   <= '0;
                        r_arr_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Row i sees A[i][k] at step i+k; column j sees B[k][j] at step k+j.
    always_comb begin
        w_a_west  = '0;
        w_b_north = '0;
        if (r_state == c_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (r_step == c_SW'(i + k)) begin
                        w_a_west[i*DW +: DW]  = r_a[i][k];
                        w_b_north[i*DW +: DW] = r_b[k][i];
                    end
                end
            end
        end
    end

    assign arr_en  = r_arr_en;
    assign arr_rst = r_arr_rst;
    assign busy    = r_busy;
    assign done    = r_done;
    assign a_west  = w_a_west;
    assign b_north = w_b_north;

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_seq_ctrl
// Brief    : Directed bench for systolic_seq_ctrl with a behavioural PE array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = $clog2(N);
    localparam int AW = 2*IW;

    logic            clk = 1'b0;
    logic            rst, start, ld_en, ld_sel;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            arr_en, arr_rst, busy, done;
    logic [N*DW-1:0] a_west, b_north;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .arr_en(arr_en), .arr_rst(arr_rst),
        .a_west(a_west), .b_north(b_north), .busy(busy), .done(done)
    );

    // Output-stationary PE array: one-cycle A/B forwarding, Q8.8 accumulate.
    logic [DW-1:0] m_a [N][N];
    logic [DW-1:0] m_b [N][N];
    logic [DW-1:0] m_c [N][N];

    function automatic logic [DW-1:0] a_in(int i, int j);
        if (j == 0) return a_west[i*DW +: DW];
        return m_a[i][j-1];
    endfunction

    function automatic logic [DW-1:0] b_in(int i, int j);
        if (i == 0) return b_north[j*DW +: DW];
        return m_b[i-1][j];
    endfunction

    function automatic logic [DW-1:0] qmul(logic [DW-1:0] a, logic [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = $signed(a) * $signed(b);
        return p[DW+7:8];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_rst) begin
                    m_a[i][j] <= '0;
                    m_b[i][j] <= '0;
                    m_c[i][j] <= '0;
                end else begin
                    m_a[i][j] <= a_in(i, j);
                    m_b[i][j] <= b_in(i, j);
                    if (arr_en) m_c[i][j] <= m_c[i][j] + qmul(a_in(i, j), b_in(i, j));
                end
            end
        end
    end

    logic            tr_rst  [0:20];
    logic            tr_en   [0:20];
    logic            tr_done [0:20];
    logic            tr_busy [0:20];
    logic [N*DW-1:0] tr_aw   [0:20];
    logic [N*DW-1:0] tr_bn   [0:20];
    logic [DW-1:0]   snap    [N][N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input bit sel, input int r, input int c, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = AW'((r << IW) | c);
        ld_data = d;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    // Cycle 0 is the cycle start is sampled in; trace covers cycles 1..20.
    // inj_kind 1: start+ld_en of A[0][0]=7777 at inj_cyc; 2: rst for 2 cycles.
    task automatic run_op(input int inj_cyc, input int inj_kind, input bit ld_now,
                          input logic [DW-1:0] ld_val);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                snap[i][j] = 16'hdead;
        start = 1'b1;
        if (ld_now) begin
            ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = ld_val;
        end
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            tr_rst[c] = arr_rst; tr_en[c] = arr_en; tr_done[c] = done;
            tr_busy[c] = busy;   tr_aw[c] = a_west; tr_bn[c] = b_north;
            if (done) snap = m_c;
            start = 1'b0;
            ld_en = 1'b0;
            if (c == inj_cyc && inj_kind == 1) begin
                start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 16'h7777;
            end
            if (c == inj_cyc && inj_kind == 2) rst = 1'b1;
            if (c == inj_cyc + 2 && inj_kind == 2) rst = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0; ld_en = 1'b0; rst = 1'b0;
    endtask

    task automatic check_timing(input string pfx);
        int n_rst = 0, n_en = 0, n_done = 0;
        int rst_c = -1, first_en = -1, last_en = -1, done_c = -1;
        for (int c = 1; c <= 20; c++) begin
            if (tr_rst[c]) begin n_rst++; if (rst_c < 0) rst_c = c; end
            if (tr_en[c]) begin n_en++; if (first_en < 0) first_en = c; last_en = c; end
            if (tr_done[c]) begin n_done++; if (done_c < 0) done_c = c; end
        end
        check({pfx, " clear_cycle"}, 64'(rst_c), 64'd1);
        check({pfx, " clear_count"}, 64'(n_rst), 64'd1);
        check({pfx, " en_first"},    64'(first_en), 64'd2);
        check({pfx, " en_last"},     64'(last_en), 64'd11);
        check({pfx, " en_count"},    64'(n_en), 64'd10);
        check({pfx, " done_cycle"},  64'(done_c), 64'd12);
        check({pfx, " done_count"},  64'(n_done), 64'd1);
        check({pfx, " busy_1_11_12"}, {tr_busy[1], tr_busy[11], tr_busy[12]}, 64'b110);
    endtask

    function automatic logic [DW-1:0] bval(int i, int j);
        return DW'(i*16'h0123 + j*16'h0041 + 16'h0011);
    endfunction

    logic [DW-1:0] acc_or;
    logic [N*DW-1:0] bus_or;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset ctrl", {arr_en, arr_rst, busy, done}, 64'd0);
        check("reset a_west", a_west, 64'd0);
        check("reset b_north", b_north, 64'd0);

        // Scalar: 1.5 * 2.0 = 3.0 in PE(0,0) only
        load(1'b0, 0, 0, 16'h0180);
        load(1'b1, 0, 0, 16'h0200);
        run_op(0, 0, 1'b0, '0);
        check_timing("scalar");
        check("scalar c00", snap[0][0], 64'h0300);
        acc_or = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != 0 || j != 0) acc_or |= snap[i][j];
        check("scalar others", acc_or, 64'd0);

        // Skew on the west edge
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                load(1'b0, i, k, DW'(16*i + k));
        load(1'b1, 0, 0, 16'h0000);
        run_op(0, 0, 1'b0, '0);
        check("skew t3", tr_aw[5], {16'd48, 16'd33, 16'd18, 16'd3});
        check("skew t6", tr_aw[8], {16'd51, 16'd0, 16'd0, 16'd0});
        check("skew t9", tr_aw[11], 64'd0);
        check("skew b t3", tr_bn[5], 64'd0);

        // Identity times B
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                load(1'b0, i, k, (i == k) ? 16'h0100 : 16'h0000);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                load(1'b1, i, j, bval(i, j));
        run_op(0, 0, 1'b0, '0);
        check_timing("ident");
        check("ident b t0", tr_bn[2], {48'd0, bval(0, 0)});
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("ident c%0d%0d", i, j), snap[i][j], bval(i, j));

        // start and ld_en during FEED are ignored
        run_op(5, 1, 1'b0, '0);
        check_timing("proto");
        check("proto a00 unchanged", tr_aw[2][DW-1:0], 64'h0100);
        check("proto c00", snap[0][0], bval(0, 0));

        // start with ld_en in IDLE: new A[0][0] used by this run
        run_op(0, 0, 1'b1, 16'h0200);
        check("ld_start a00", tr_aw[2][DW-1:0], 64'h0200);
        check("ld_start c00", snap[0][0], DW'(2*bval(0, 0)));
        check("ld_start c11", snap[1][1], bval(1, 1));

        // Reset mid-FEED aborts and clears the buffers
        run_op(5, 2, 1'b0, '0);
        check("abort ctrl c7", {tr_en[7], tr_rst[7], tr_busy[7], tr_done[7]}, 64'd0);
        check("abort a_west c7", tr_aw[7], 64'd0);
        begin
            int nd = 0;
            for (int c = 1; c <= 20; c++) if (tr_done[c]) nd++;
            check("abort no done", 64'(nd), 64'd0);
        end
        run_op(0, 0, 1'b0, '0);
        check_timing("post_rst");
        bus_or = '0;
        for (int c = 1; c <= 20; c++) bus_or |= tr_aw[c] | tr_bn[c];
        check("post_rst buses", bus_or, 64'd0);
        acc_or = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                acc_or |= snap[i][j];
        check("post_rst results", acc_or, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
